writeback_unit: RTL

Drives the single register-file write port of the RV32I core. Accepts results from two producers, the ALU path and the load path, and arbitrates between them. Load data is aligned and sign- or zero-extended per `funct3`. Registered writes (`we`/`waddr`/`wdata`) are issued one cycle after acceptance, and a 32-bit pending-load scoreboard is kept for hazard detection. All writes to x0 are suppressed.

---
 rtl/writeback_unit_if.sv | 38 +++
 rtl/writeback_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/writeback_unit_if.sv
// Producer/register-file bundle for the writeback unit: ALU and load result channels,
// write port, scoreboard and load-error outputs.
interface writeback_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic [4:0]           alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 ld_issue;
    logic [4:0]           ld_issue_rd;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [4:0]           ld_rd;
    logic [XLEN-1:0]      ld_data;
    logic [2:0]           ld_funct3;
    logic [1:0]           ld_offset;
    logic                 we;
    logic [4:0]           waddr;
    logic [XLEN-1:0]      wdata;
    logic [REG_COUNT-1:0] busy;
    logic                 ld_err;

    // Producer side: drives results and observes the register-file port.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
        input  alu_ready, ld_ready, we, waddr, wdata, busy, ld_err
    );

    // Writeback unit side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
        output alu_ready, ld_ready, we, waddr, wdata, busy, ld_err
    );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write port arbiter for the RV32I core: load responses beat ALU results,
// loads are aligned/extended, and a pending-load scoreboard tracks outstanding destinations.
module writeback_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    writeback_unit_if.slave       bus
);
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic                 ld_acc;
    logic                 alu_acc;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [XLEN-1:0]      ld_ext;
    logic                 ld_bad;

    logic                 we_q,     we_d;
    logic [4:0]           waddr_q,  waddr_d;
    logic [XLEN-1:0]      wdata_q,  wdata_d;
    logic [REG_COUNT-1:0] busy_q,   busy_d;
    logic                 ld_err_q, ld_err_d;

    // Loads always win; the ALU stalls whenever a load response is presented.
    assign bus.ld_ready  = !reset;
    assign bus.alu_ready = !reset && !bus.ld_valid;
    assign ld_acc        = bus.ld_valid && !reset;
    assign alu_acc       = bus.alu_valid && !reset && !bus.ld_valid;

    assign ld_byte = bus.ld_data[{bus.ld_offset, 3'b000} +: 8];
    assign ld_half = bus.ld_offset[1] ? bus.ld_data[31:16] : bus.ld_data[15:0];

    // Extension and legality check for the presented load response.
    always_comb begin
        ld_ext = '0;
        ld_bad = 1'b0;
        case (bus.ld_funct3)
            F3_LB:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU: ld_ext = XLEN'(ld_byte);
            F3_LH: begin
                ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_bad = bus.ld_offset[0];
            end
            F3_LHU: begin
                ld_ext = XLEN'(ld_half);
                ld_bad = bus.ld_offset[0];
            end
            F3_LW: begin
                ld_ext = bus.ld_data;
                ld_bad = (bus.ld_offset != 2'b00);
            end
            default: ld_bad = 1'b1;
        endcase
    end

    // Write-stage and scoreboard next state; address/data hold unless a real write issues.
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        ld_err_d = 1'b0;
        busy_d   = busy_q;
        if (ld_acc) begin
            ld_err_d = ld_bad;
            busy_d[bus.ld_rd] = 1'b0;
            if (!ld_bad && bus.ld_rd != 5'd0) begin
                we_d    = 1'b1;
                waddr_d = bus.ld_rd;
                wdata_d = ld_ext;
            end
        end else if (alu_acc && bus.alu_rd != 5'd0) begin
            we_d    = 1'b1;
            waddr_d = bus.alu_rd;
            wdata_d = bus.alu_data;
        end
        // A fresh issue to the same register overrides the clear from its older response.
        if (bus.ld_issue && bus.ld_issue_rd != 5'd0) begin
            busy_d[bus.ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
            ld_err_q <= 1'b0;
        end else begin
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign bus.we     = we_q;
    assign bus.waddr  = waddr_q;
    assign bus.wdata  = wdata_q;
    assign bus.busy   = busy_q;
    assign bus.ld_err = ld_err_q;
endmodule
